md5_candidate_generator: RTL and testbench

Produces one padded 512-bit MD5 message block per clock for the brute-force search. It enumerates every string from length 1 up to `MAX_LEN` over a printable byte range `[min, max]` and sits directly upstream of the MD5 core pipeline, driving its `wb` input. It also exports the candidate count and an exhaustion flag to the command controller.

---
 rtl/md5_gen_pkg.sv | 20 ++
 rtl/md5_chunk_pack.sv | 28 ++
 rtl/md5_candidate_generator.sv | 120 ++++++++++++
 tb/tb_md5_candidate_generator.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/md5_gen_pkg.sv
// Shared constants and state encoding for the MD5 candidate generator.
package md5_gen_pkg;

    localparam int         CHUNK_W       = 512;
    localparam logic [7:0] PAD_BYTE      = 8'h80;
    localparam int         LEN_LSB       = 448;
    localparam int         MAX_LEN_LIMIT = 15;
    localparam int         LEN_W         = 4;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } gen_state_t;

    // An inverted range collapses to a one-symbol alphabet at min.
    function automatic logic [7:0] range_hi(input logic [7:0] lo, input logic [7:0] hi);
        return (hi < lo) ? lo : hi;
    endfunction

endpackage

// File: rtl/md5_chunk_pack.sv
// Combinational packer: string bytes, 0x80 pad and 64-bit bit length into one MD5 block.
module md5_chunk_pack
    import md5_gen_pkg::*;
#(
    parameter int MAX_LEN = 8
) (
    input  logic [LEN_W-1:0]     len,
    input  logic [8*MAX_LEN-1:0] ch,
    output logic [CHUNK_W-1:0]   chunk
);

    always_comb begin
        chunk = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(len)) begin
                chunk[8*i +: 8] = ch[8*i +: 8];
            end
        end
        for (int i = 0; i <= MAX_LEN; i++) begin
            if (i == int'(len)) begin
                chunk[8*i +: 8] = PAD_BYTE;
            end
        end
        // Message length in bits, little-endian, occupies the last 8 bytes.
        chunk[LEN_LSB +: 64] = {{(64-LEN_W-3){1'b0}}, len, 3'b000};
    end

endmodule

// File: rtl/md5_candidate_generator.sv
// Enumerates all strings of length 1..MAX_LEN over [min,max], one padded MD5 block per clock.
// Optional build macro MD5GEN_WRAP_EN: restart at length 1 on exhaustion instead of stopping.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_RUN  | chunk holds a live candidate; advances on valid && enable
// ST_DONE | keyspace exhausted; chunk/count frozen until reset
module md5_candidate_generator
    import md5_gen_pkg::*;
#(
    parameter int MAX_LEN = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [7:0]         min,
    input  logic [7:0]         max,
    output logic [CHUNK_W-1:0] chunk,
    output logic               valid,
    output logic               done,
    output logic [63:0]        count
);

    logic [7:0]           min_q;
    logic [7:0]           max_q;
    logic [LEN_W-1:0]     len_q;
    logic [LEN_W-1:0]     len_d;
    logic [8*MAX_LEN-1:0] ch_q;
    logic [8*MAX_LEN-1:0] ch_d;
    logic [8*MAX_LEN-1:0] ch_inc;
    logic                 carry;
    logic                 accept;
    gen_state_t           state_q;
    gen_state_t           state_d;
    logic                 valid_d;
    logic                 done_d;
    logic [63:0]          count_d;
    logic [CHUNK_W-1:0]   chunk_d;

    // Ripple increment across the active digits; carry survives only if every digit wrapped.
    always_comb begin
        ch_inc = ch_q;
        carry  = 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (carry && (i < int'(len_q))) begin
                if (ch_q[8*i +: 8] == max_q) begin
                    ch_inc[8*i +: 8] = min_q;
                end else begin
                    ch_inc[8*i +: 8] = ch_q[8*i +: 8] + 8'd1;
                    carry            = 1'b0;
                end
            end
        end
    end

    assign accept = (state_q == ST_RUN) && valid && enable;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        ch_d    = ch_q;
        count_d = count;
        done_d  = 1'b0;
        if (reset) begin
            state_d = ST_RUN;
            len_d   = LEN_W'(1);
            ch_d    = {MAX_LEN{min}};
            count_d = '0;
        end else if (accept) begin
            count_d = count + 64'd1;
            if (!carry) begin
                ch_d = ch_inc;
            end else if (int'(len_q) < MAX_LEN) begin
                len_d = len_q + 1'b1;
                ch_d  = {MAX_LEN{min_q}};
            end else begin
`ifdef MD5GEN_WRAP_EN
                len_d  = LEN_W'(1);
                ch_d   = {MAX_LEN{min_q}};
                done_d = 1'b1;
`else
                state_d = ST_DONE;
`endif
            end
        end
`ifndef MD5GEN_WRAP_EN
        done_d = (state_d == ST_DONE);
`endif
        valid_d = !reset && (state_d == ST_RUN);
    end

    // Packing the next-state values keeps chunk aligned with len/ch after each edge.
    md5_chunk_pack #(
        .MAX_LEN (MAX_LEN)
    ) u_pack (
        .len   (len_d),
        .ch    (ch_d),
        .chunk (chunk_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            min_q   <= min;
            max_q   <= range_hi(min, max);
            state_q <= ST_RUN;
            valid   <= 1'b0;
            done    <= 1'b0;
            count   <= '0;
        end else begin
            state_q <= state_d;
            valid   <= valid_d;
            done    <= done_d;
            count   <= count_d;
        end
        len_q <= len_d;
        ch_q  <= ch_d;
        chunk <= chunk_d;
    end

endmodule

// File: tb/tb_md5_candidate_generator.sv
// Directed bench for md5_candidate_generator; MD5GEN_WRAP_EN selects the wrap-mode scenario.
module tb_md5_candidate_generator;

`ifdef MD5GEN_WRAP_EN
    localparam int ML = 1;
`else
    localparam int ML = 2;
`endif

    logic         clk    = 1'b0;
    logic         reset  = 1'b1;
    logic         enable = 1'b0;
    logic [7:0]   min    = 8'h61;
    logic [7:0]   max    = 8'h63;
    logic [511:0] chunk;
    logic         valid;
    logic         done;
    logic [63:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    md5_candidate_generator #(
        .MAX_LEN (ML)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .min    (min),
        .max    (max),
        .chunk  (chunk),
        .valid  (valid),
        .done   (done),
        .count  (count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] enc(input int n, input logic [7:0] b0, input logic [7:0] b1);
        logic [511:0] c;
        c         = '0;
        c[7:0]    = b0;
        if (n == 2) c[15:8] = b1;
        c[8*n +: 8]    = 8'h80;
        c[511:448]     = 64'(n * 8);
        return c;
    endfunction

    // Two reset cycles, release, then one edge so the first candidate is visible.
    task automatic start(input logic [7:0] lo, input logic [7:0] hi);
        reset  = 1'b1;
        min    = lo;
        max    = hi;
        enable = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
`ifdef MD5GEN_WRAP_EN
        start(8'h61, 8'h62);
        check("w_a_chunk", chunk, enc(1, 8'h61, 8'h00));
        check("w_a_valid", valid, 1);
        check("w_a_done",  done,  0);
        check("w_a_count", count, 0);
        step();
        check("w_b_chunk", chunk, enc(1, 8'h62, 8'h00));
        check("w_b_count", count, 1);
        check("w_b_done",  done,  0);
        step();
        check("w_a2_chunk", chunk, enc(1, 8'h61, 8'h00));
        check("w_a2_done",  done,  1);
        check("w_a2_valid", valid, 1);
        check("w_a2_count", count, 2);
        step();
        check("w_b2_chunk", chunk, enc(1, 8'h62, 8'h00));
        check("w_b2_done",  done,  0);
        check("w_b2_valid", valid, 1);
        check("w_b2_count", count, 3);
`else
        // Sequence over "abc" up to length 2.
        reset  = 1'b1;
        enable = 1'b1;
        step();
        step();
        check("rst_chunk", chunk, enc(1, 8'h61, 8'h00));
        check("rst_valid", valid, 0);
        check("rst_done",  done,  0);
        check("rst_count", count, 0);
        reset = 1'b0;
        step();
        check("first_b0",   chunk[7:0],     8'h61);
        check("first_b1",   chunk[15:8],    8'h80);
        check("first_len",  chunk[511:448], 64'd8);
        check("first_zero", chunk[447:16],  '0);
        for (int k = 0; k < 12; k++) begin
            logic [511:0] e;
            if (k < 3) e = enc(1, 8'h61 + 8'(k), 8'h00);
            else       e = enc(2, 8'h61 + 8'((k - 3) % 3), 8'h61 + 8'((k - 3) / 3));
            check($sformatf("seq%0d_chunk", k), chunk, e);
            check($sformatf("seq%0d_valid", k), valid, 1);
            check($sformatf("seq%0d_count", k), count, 512'(k));
            check($sformatf("seq%0d_done", k),  done,  0);
            step();
        end
        for (int r = 0; r < 3; r++) begin
            check("end_chunk", chunk, enc(2, 8'h63, 8'h63));
            check("end_done",  done,  1);
            check("end_valid", valid, 0);
            check("end_count", count, 12);
            step();
        end

        // Alternating enable over a-z; later range changes must be ignored.
        start(8'h61, 8'h7a);
        min = 8'h00;
        max = 8'hff;
        for (int k = 0; k < 26; k++) begin
            enable = 1'b0;
            check($sformatf("tog%0d_lo_chunk", k), chunk, enc(1, 8'h61 + 8'(k), 8'h00));
            check($sformatf("tog%0d_lo_count", k), count, 512'(k));
            step();
            check($sformatf("tog%0d_hold_chunk", k), chunk, enc(1, 8'h61 + 8'(k), 8'h00));
            check($sformatf("tog%0d_hold_count", k), count, 512'(k));
            enable = 1'b1;
            step();
        end
        check("roll_chunk", chunk, enc(2, 8'h61, 8'h61));
        check("roll_len",   chunk[511:448], 64'd16);
        check("roll_count", count, 26);

        // Inverted range: one-symbol alphabet "z".
        start(8'h7a, 8'h61);
        check("one_z_chunk", chunk, enc(1, 8'h7a, 8'h00));
        check("one_z_count", count, 0);
        step();
        check("one_zz_chunk", chunk, enc(2, 8'h7a, 8'h7a));
        check("one_zz_count", count, 1);
        check("one_zz_done",  done,  0);
        step();
        check("one_end_done",  done,  1);
        check("one_end_valid", valid, 0);
        check("one_end_count", count, 2);
        check("one_end_chunk", chunk, enc(2, 8'h7a, 8'h7a));

        // Reset after five candidates with a new min.
        start(8'h61, 8'h63);
        for (int k = 0; k < 5; k++) step();
        check("mid_chunk", chunk, enc(2, 8'h63, 8'h61));
        check("mid_count", count, 5);
        reset = 1'b1;
        min   = 8'h41;
        step();
        check("mid_rst_chunk", chunk, enc(1, 8'h41, 8'h00));
        check("mid_rst_valid", valid, 0);
        check("mid_rst_count", count, 0);
        reset = 1'b0;
        step();
        check("mid_A_chunk", chunk, enc(1, 8'h41, 8'h00));
        check("mid_A_valid", valid, 1);
        check("mid_A_count", count, 0);
        step();
        check("mid_B_chunk", chunk, enc(1, 8'h42, 8'h00));
        check("mid_B_count", count, 1);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
